stage_pc_responder: RTL

//  Responder end of the toggle-encoded stage interface driven by the stage sequencer.

---
 rtl/stage_pc_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stage_pc_responder.sv
// Responder end of the toggle-encoded IF/ID/EX/MEM/WB stage interface.
// Turns stage toggles into pulses, enforces stage order, tracks the next PC and retire count.
module stage_pc_responder #(
  parameter int PC_WIDTH    = 8,
  parameter int PC_STEP     = 1,
  parameter int RESET_PC    = 0,
  parameter int STALL_LIMIT = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 startbit,
  input  logic                 if_stage,
  input  logic                 id_stage,
  input  logic                 ex_stage,
  input  logic                 mem_stage,
  input  logic                 wb_stage,
  input  logic [PC_WIDTH-1:0]  new_pc,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 halt,
  output logic [PC_WIDTH-1:0]  current_pc,
  output logic                 if_pulse,
  output logic                 id_pulse,
  output logic                 ex_pulse,
  output logic                 mem_pulse,
  output logic                 wb_pulse,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 halted,
  output logic                 seq_error,
  output logic [1:0]           err_code
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    EXP_IF  = 3'd0,
    EXP_ID  = 3'd1,
    EXP_EX  = 3'd2,
    EXP_MEM = 3'd3,
    EXP_WB  = 3'd4,
    HALT    = 3'd5,
    ERR     = 3'd6
  } state_e;

  localparam logic [1:0] ERR_ORDER = 2'd1;
  localparam logic [1:0] ERR_STALL = 2'd2;
  localparam logic [1:0] ERR_ECHO  = 2'd3;

  logic [4:0]           stage_in;
  logic [4:0]           prev_q;
  logic [4:0]           edges;
  logic [4:0]           exp_mask;
  logic [4:0]           pulse_q;
  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  tgt_q, tgt_d;
  logic                 bpend_q, bpend_d;
  logic                 echo_q, echo_d;
  logic                 retire_q, retire_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           code_q, code_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 running;

  // Bit index of every stage vector equals the FSM encoding of the state expecting it.
  assign stage_in = {wb_stage, mem_stage, ex_stage, id_stage, if_stage};
  assign edges    = (stage_in ^ prev_q) & {5{startbit}};
  assign running  = (state_q != HALT) && (state_q != ERR);

  always_comb begin
    exp_mask = 5'b00000;
    case (state_q)
      EXP_IF:  exp_mask = 5'b00001;
      EXP_ID:  exp_mask = 5'b00010;
      EXP_EX:  exp_mask = 5'b00100;
      EXP_MEM: exp_mask = 5'b01000;
      EXP_WB:  exp_mask = 5'b10000;
      default: exp_mask = 5'b00000;
    endcase
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch below can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    bpend_d  = bpend_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    stall_d  = stall_q;
    echo_d   = 1'b0;
    retire_d = 1'b0;

    if (running) begin
      // The sequencer's latched PC shows up one cycle after the IF edge.
      if (echo_q && (new_pc != pc_q)) begin
        state_d = ERR;
        code_d  = ERR_ECHO;
      end else if (|edges) begin
        stall_d = '0;
        if (edges != exp_mask) begin
          state_d = ERR;
          code_d  = ERR_ORDER;
        end else begin
          case (state_q)
            EXP_IF: begin
              state_d = EXP_ID;
              echo_d  = 1'b1;
            end
            EXP_ID:  state_d = EXP_EX;
            EXP_EX: begin
              state_d = EXP_MEM;
              bpend_d = branch_taken;
              tgt_d   = branch_target;
            end
            EXP_MEM: state_d = EXP_WB;
            default: begin
              pc_d     = bpend_q ? tgt_q : pc_q + PC_WIDTH'(PC_STEP);
              bpend_d  = 1'b0;
              retire_d = 1'b1;
              cnt_d    = cnt_q + CNT_WIDTH'(1);
              state_d  = halt ? HALT : EXP_IF;
            end
          endcase
        end
      end else if (startbit) begin
        stall_d = stall_q + STALL_W'(1);
        if (stall_d == STALL_W'(STALL_LIMIT)) begin
          state_d = ERR;
          code_d  = ERR_STALL;
        end
      end
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
  always_ff @(posedge clock) begin
    prev_q <= stage_in;
    if (reset) begin
      state_q  <= EXP_IF;
      pc_q     <= PC_WIDTH'(RESET_PC);
      tgt_q    <= '0;
      bpend_q  <= 1'b0;
      echo_q   <= 1'b0;
      retire_q <= 1'b0;
      cnt_q    <= '0;
      code_q   <= '0;
      stall_q  <= '0;
      pulse_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      bpend_q  <= bpend_d;
      echo_q   <= echo_d;
      retire_q <= retire_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      stall_q  <= stall_d;
      pulse_q  <= edges;
    end
  end

  assign current_pc  = pc_q;
  assign if_pulse    = pulse_q[0];
  assign id_pulse    = pulse_q[1];
  assign ex_pulse    = pulse_q[2];
  assign mem_pulse   = pulse_q[3];
  assign wb_pulse    = pulse_q[4];
  assign retire      = retire_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == HALT);
  assign seq_error   = (state_q == ERR);
  assign err_code    = code_q;

endmodule
